// File: rtl/ysyx_23060136_pipe_skid_seg_if.sv
// Beat channel between pipeline stages: valid/ready handshake carrying pc, inst and payload.
interface ysyx_23060136_pipe_skid_seg_if #(
  parameter int unsigned PC_W   = 64,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DATA_W = 128
);
  logic              valid;
  logic              ready;
  logic [PC_W-1:0]   pc;
  logic [INST_W-1:0] inst;
  logic [DATA_W-1:0] data;

  // Producer side drives the beat, consumer side drives ready.
  modport master (output valid, pc, inst, data, input ready);
  modport slave  (input valid, pc, inst, data, output ready);
endinterface

// File: rtl/ysyx_23060136_pipe_skid_seg.sv
// Inter-stage pipeline segment with a 2-entry skid buffer (main + skid registers).
// Full throughput with a registered in_ready; flush squashes held and incoming beats.
// Optional feature macro: YSYX_23060136_SEG_PERF_EN enables stall/flush perf counters.
module ysyx_23060136_pipe_skid_seg #(
  parameter int unsigned       PC_W   = 64,
  parameter int unsigned       INST_W = 32,
  parameter int unsigned       DATA_W = 128,
  parameter logic [PC_W-1:0]   PC_RST = PC_W'(64'h8000_0000),
  parameter logic [INST_W-1:0] NOP    = INST_W'(32'h0000_0013)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  ysyx_23060136_pipe_skid_seg_if.slave          in_bus,
  ysyx_23060136_pipe_skid_seg_if.master         out_bus,
  output logic [31:0]                           perf_stall_cnt,
  output logic [31:0]                           perf_flush_cnt
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic [DATA_W-1:0] data;
  } beat_t;

  localparam beat_t RST_BEAT = '{pc: PC_RST, inst: NOP, data: '0};

  state_e state_q, state_d;
  beat_t  main_q, main_d;
  beat_t  skid_q, skid_d;
  beat_t  in_beat;
  logic   valid_q, valid_d;
  logic   ready_q, ready_d;
  logic   push, pop;

  assign in_beat = '{pc: in_bus.pc, inst: in_bus.inst, data: in_bus.data};
  assign push    = in_bus.valid & ready_q;
  assign pop     = valid_q & out_bus.ready;

  // State, storage and handshake flags; handshake flags mirror the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= RST_BEAT;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and storage update; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = RST_BEAT;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d = S_ONE;
            main_d  = in_beat;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            main_d = in_beat;
          end else if (push) begin
            state_d = S_TWO;
            skid_d  = in_beat;
          end else if (pop) begin
            state_d = S_EMPTY;
            main_d  = RST_BEAT;
          end
        end
        S_TWO: begin
          if (pop) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = RST_BEAT;
          skid_d  = '0;
        end
      endcase
    end
    valid_d = (state_d != S_EMPTY);
    ready_d = (state_d != S_TWO);
  end

  assign in_bus.ready  = ready_q;
  assign out_bus.valid = valid_q;
  assign out_bus.pc    = main_q.pc;
  assign out_bus.inst  = main_q.inst;
  assign out_bus.data  = main_q.data;

`ifdef YSYX_23060136_SEG_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Saturating counters: stalled cycles, and flushes that squashed a held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (valid_q && !out_bus.ready && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (flush && (state_q != S_EMPTY) && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_q;
`else
  assign perf_stall_cnt = CNT_W'(0);
  assign perf_flush_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_ysyx_23060136_pipe_skid_seg.sv
// Directed and randomized checks of the skid-buffer pipeline segment.
module tb_ysyx_23060136_pipe_skid_seg;

  localparam int unsigned PC_W   = 64;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DATA_W = 128;
  localparam logic [63:0]  PC0   = 64'h8000_0000;
  localparam logic [31:0]  NOPI  = 32'h0000_0013;

`ifdef YSYX_23060136_SEG_PERF_EN
  localparam logic [31:0] EXP_STALL5 = 32'd5;
  localparam logic [31:0] EXP_FLUSH1 = 32'd1;
`else
  localparam logic [31:0] EXP_STALL5 = 32'd0;
  localparam logic [31:0] EXP_FLUSH1 = 32'd0;
`endif

  typedef struct {
    logic [63:0]  pc;
    logic [31:0]  inst;
    logic [127:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
  int          errors = 0;
  int          checks = 0;

  ysyx_23060136_pipe_skid_seg_if #(.PC_W(PC_W), .INST_W(INST_W), .DATA_W(DATA_W)) in_if ();
  ysyx_23060136_pipe_skid_seg_if #(.PC_W(PC_W), .INST_W(INST_W), .DATA_W(DATA_W)) out_if ();

  ysyx_23060136_pipe_skid_seg dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_bus         (in_if),
    .out_bus        (out_if),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                       input logic [127:0] data, input logic ordy, input logic fl);
    in_if.valid  = v;
    in_if.pc     = pc;
    in_if.inst   = inst;
    in_if.data   = data;
    out_if.ready = ordy;
    flush        = fl;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 64'h0, 32'h0, 128'h0, 1'b0, 1'b0);
    tick();
    tick();
    checks++; if (out_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_if.valid); end
    checks++; if (in_if.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_if.ready); end
    checks++; if (out_if.pc !== PC0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", out_if.pc, PC0); end
    checks++; if (out_if.inst !== NOPI) begin errors++; $display("FAIL reset_inst got=%h exp=%h", out_if.inst, NOPI); end
    checks++; if (out_if.data !== 128'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_if.data); end
    checks++; if (perf_stall_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin
      errors++; $display("FAIL reset_perf got=%h/%h exp=0/0", perf_stall_cnt, perf_flush_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    logic [63:0] exp_pc;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, PC0 + 64'(4 * k), 32'h100 + 32'(k), 128'(k * 3), 1'b1, 1'b0);
      tick();
      exp_pc = PC0 + 64'(4 * k);
      checks++; if (out_if.valid !== 1'b1 || in_if.ready !== 1'b1) begin
        errors++; $display("FAIL stream_hs k=%0d got v=%b r=%b exp v=1 r=1", k, out_if.valid, in_if.ready);
      end
      checks++; if (out_if.pc !== exp_pc || out_if.inst !== 32'h100 + 32'(k) || out_if.data !== 128'(k * 3)) begin
        errors++; $display("FAIL stream_beat k=%0d got pc=%h inst=%h exp pc=%h inst=%h", k, out_if.pc, out_if.inst,
                           exp_pc, 32'h100 + 32'(k));
      end
    end
    drive(1'b0, 64'h0, 32'h0, 128'h0, 1'b1, 1'b0);
    tick();
    checks++; if (out_if.valid !== 1'b0 || out_if.pc !== PC0 || out_if.inst !== NOPI || out_if.data !== 128'h0) begin
      errors++; $display("FAIL stream_drain got v=%b pc=%h inst=%h exp v=0 pc=%h inst=%h", out_if.valid, out_if.pc,
                         out_if.inst, PC0, NOPI);
    end
  endtask

  task automatic test_skid();
    drive(1'b1, 64'hA0, 32'h0A0, 128'hA0, 1'b0, 1'b0);
    tick();
    checks++; if (out_if.valid !== 1'b1 || in_if.ready !== 1'b1 || out_if.pc !== 64'hA0) begin
      errors++; $display("FAIL skid_one got v=%b r=%b pc=%h exp v=1 r=1 pc=a0", out_if.valid, in_if.ready, out_if.pc);
    end
    drive(1'b1, 64'hA4, 32'h0A4, 128'hA4, 1'b0, 1'b0);
    tick();
    checks++; if (out_if.valid !== 1'b1 || in_if.ready !== 1'b0 || out_if.pc !== 64'hA0) begin
      errors++; $display("FAIL skid_two got v=%b r=%b pc=%h exp v=1 r=0 pc=a0", out_if.valid, in_if.ready, out_if.pc);
    end
    drive(1'b1, 64'hA8, 32'h0A8, 128'hA8, 1'b1, 1'b0);
    tick();
    checks++; if (out_if.valid !== 1'b1 || out_if.pc !== 64'hA4 || out_if.data !== 128'hA4 || in_if.ready !== 1'b1) begin
      errors++; $display("FAIL skid_pop1 got v=%b pc=%h r=%b exp v=1 pc=a4 r=1", out_if.valid, out_if.pc, in_if.ready);
    end
    drive(1'b0, 64'h0, 32'h0, 128'h0, 1'b1, 1'b0);
    tick();
    checks++; if (out_if.valid !== 1'b0 || out_if.pc !== PC0) begin
      errors++; $display("FAIL skid_pop2 got v=%b pc=%h exp v=0 pc=%h", out_if.valid, out_if.pc, PC0);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 64'hD0, 32'h0D0, 128'hD0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 64'h0, 32'h0, 128'h0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1 || out_if.pc !== PC0 || out_if.inst !== NOPI) begin
      errors++; $display("FAIL async_reset got v=%b r=%b pc=%h inst=%h exp v=0 r=1 pc=%h inst=%h", out_if.valid,
                         in_if.ready, out_if.pc, out_if.inst, PC0, NOPI);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_backpressure();
    logic [63:0]  h_pc;
    logic [31:0]  h_inst;
    logic [127:0] h_data;
    h_pc   = 64'hB0;
    h_inst = 32'hDEAD_BEEF;
    h_data = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    drive(1'b1, h_pc, h_inst, h_data, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 64'hFF, 32'hFF, 128'hFF, 1'b0, 1'b0);
      tick();
      checks++; if (out_if.valid !== 1'b1 || out_if.pc !== h_pc || out_if.inst !== h_inst || out_if.data !== h_data) begin
        errors++; $display("FAIL bp_hold c=%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h", c, out_if.valid,
                           out_if.pc, out_if.inst, h_pc, h_inst);
      end
    end
    checks++; if (perf_stall_cnt !== EXP_STALL5) begin
      errors++; $display("FAIL bp_stall_cnt got=%0d exp=%0d", perf_stall_cnt, EXP_STALL5);
    end
    drive(1'b0, 64'h0, 32'h0, 128'h0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 64'hC0, 32'h0C0, 128'hC0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'hC4, 32'h0C4, 128'hC4, 1'b0, 1'b0);
    tick();
    checks++; if (in_if.ready !== 1'b0) begin errors++; $display("FAIL flush_pre got r=%b exp r=0", in_if.ready); end
    drive(1'b1, 64'hC8, 32'h0C8, 128'hC8, 1'b0, 1'b1);
    tick();
    checks++; if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1 || out_if.pc !== PC0 || out_if.inst !== NOPI ||
                  out_if.data !== 128'h0) begin
      errors++; $display("FAIL flush_empty got v=%b r=%b pc=%h inst=%h exp v=0 r=1 pc=%h inst=%h", out_if.valid,
                         in_if.ready, out_if.pc, out_if.inst, PC0, NOPI);
    end
    drive(1'b0, 64'h0, 32'h0, 128'h0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 64'h0, 32'h0, 128'h0, 1'b1, 1'b0);
    tick();
    checks++; if (out_if.valid !== 1'b0) begin
      errors++; $display("FAIL flush_no_emit got v=%b exp v=0", out_if.valid);
    end
    checks++; if (perf_flush_cnt !== EXP_FLUSH1) begin
      errors++; $display("FAIL flush_cnt got=%0d exp=%0d", perf_flush_cnt, EXP_FLUSH1);
    end
  endtask

  task automatic test_random();
    beat_t q[$];
    beat_t b;
    logic  v, r, f;
    logic  mpush, mpop;
    int    seq;
    seq = 0;
    drive(1'b0, 64'h0, 32'h0, 128'h0, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checks++; if (out_if.valid !== (q.size() > 0) || in_if.ready !== (q.size() < 2)) begin
        errors++; $display("FAIL rand_hs cyc=%0d got v=%b r=%b exp v=%b r=%b", cyc, out_if.valid, in_if.ready,
                           q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        checks++; if (out_if.pc !== q[0].pc || out_if.inst !== q[0].inst || out_if.data !== q[0].data) begin
          errors++; $display("FAIL rand_beat cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h", cyc, out_if.pc,
                             out_if.inst, q[0].pc, q[0].inst);
        end
      end else begin
        checks++; if (out_if.pc !== PC0 || out_if.inst !== NOPI || out_if.data !== 128'h0) begin
          errors++; $display("FAIL rand_empty cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h", cyc, out_if.pc,
                             out_if.inst, PC0, NOPI);
        end
      end
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 39) == 0);
      b.pc   = PC0 + 64'(4 * seq);
      b.inst = $urandom;
      b.data = {$urandom, $urandom, $urandom, $urandom};
      drive(v, b.pc, b.inst, b.data, r, f);
      if (f) begin
        q.delete();
      end else begin
        mpush = v && (q.size() < 2);
        mpop  = r && (q.size() > 0);
        if (mpop) void'(q.pop_front());
        if (mpush) q.push_back(b);
      end
      seq++;
      tick();
    end
    drive(1'b0, 64'h0, 32'h0, 128'h0, 1'b1, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid();
    test_async_reset();
    test_backpressure();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
